// File: rtl/apb_master_slave_pair.sv
// ---------------------------------------------------------------------------
// apb_master_slave_pair
//
// A self-contained APB3 subsystem made of two parts:
//   * a master that turns a single-cycle `start` request into one
//     SETUP/ACCESS transfer;
//   * a slave register-file memory with a fixed number of wait states.
// The APB bus between them is exported as outputs for observation only.
//
// Parameters
//   ADDR_WIDTH  : width of addr / paddr
//   DATA_WIDTH  : width of wdata / rdata / pwdata / prdata
//   MEM_DEPTH   : number of slave words (valid addresses 0..MEM_DEPTH-1)
//   WAIT_STATES : ACCESS cycles with pready low before pready rises (0..7)
//
// Ports
//   pclk, presetn     : clock (rising edge), asynchronous active-low reset
//   start             : request pulse, sampled only while the master is idle
//   write/addr/wdata  : transfer kind, address and write data, taken with start
//   rdata             : data of the last completed read
//   done              : one-cycle completion pulse
//   err               : slave error of the last transfer (valid with done)
//   psel ... pslverr  : observed APB signals
// ---------------------------------------------------------------------------
module apb_master_slave_pair #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  start,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    // Memory index width; at least one bit so a depth of 1 still works.
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Range limit one bit wider than paddr so the full address is compared
    // without the depth being truncated.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    // Wait-state target as a 3-bit value, matching the counter width.
    localparam logic [2:0] WAIT_LIM = 3'(WAIT_STATES);

    // -----------------------------------------------------------------------
    // Master
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } state_t;

    state_t                state_r;
    state_t                state_s;

    logic                  psel_r;
    logic                  psel_s;
    logic                  penable_r;
    logic                  penable_s;
    logic                  pwrite_r;
    logic                  pwrite_s;
    logic [ADDR_WIDTH-1:0] paddr_r;
    logic [ADDR_WIDTH-1:0] paddr_s;
    logic [DATA_WIDTH-1:0] pwdata_r;
    logic [DATA_WIDTH-1:0] pwdata_s;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [DATA_WIDTH-1:0] rdata_s;
    logic                  done_r;
    logic                  done_s;
    logic                  err_r;
    logic                  err_s;

    // Slave-side signals used by the master.
    logic                  pready_s;
    logic                  pslverr_s;
    logic [DATA_WIDTH-1:0] prdata_s;

    // Master state and all bus/user outputs are registered together, so
    // psel/penable change exactly on the edge that moves the FSM.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r   <= ST_IDLE;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= '0;
            pwdata_r  <= '0;
            rdata_r   <= '0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            psel_r    <= psel_s;
            penable_r <= penable_s;
            pwrite_r  <= pwrite_s;
            paddr_r   <= paddr_s;
            pwdata_r  <= pwdata_s;
            rdata_r   <= rdata_s;
            done_r    <= done_s;
            err_r     <= err_s;
        end
    end

    // Next-state and next-output logic for the master FSM. The values
    // computed here are what the registered outputs show in the next cycle.
    always_comb begin
        state_s   = state_r;
        psel_s    = 1'b0;
        penable_s = 1'b0;
        pwrite_s  = pwrite_r;
        paddr_s   = paddr_r;
        pwdata_s  = pwdata_r;
        rdata_s   = rdata_r;
        done_s    = 1'b0;
        err_s     = err_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_SETUP;
                    psel_s   = 1'b1;
                    pwrite_s = write;
                    paddr_s  = addr;
                    pwdata_s = wdata;
                end else begin
                    state_s  = ST_IDLE;
                end
            end

            ST_SETUP: begin
                state_s   = ST_ACCESS;
                psel_s    = 1'b1;
                penable_s = 1'b1;
            end

            ST_ACCESS: begin
                if (pready_s) begin
                    // Completion: back to IDLE with a done pulse next cycle.
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                    err_s   = pslverr_s;
                    if (!pwrite_r) begin
                        rdata_s = prdata_s;
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else begin
                    state_s   = ST_ACCESS;
                    psel_s    = 1'b1;
                    penable_s = 1'b1;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Slave
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];
    logic [2:0]            wait_cnt_r;
    logic                  addr_ok_s;
    logic [IDX_W-1:0]      idx_s;

    // The range check uses the whole address; only then are the low bits
    // used as the memory index, so out-of-range addresses never alias.
    always_comb begin
        addr_ok_s = ({1'b0, paddr_r} < DEPTH_LIM);
        idx_s     = paddr_r[IDX_W-1:0];
    end

    // Ready and error responses of the slave.
    always_comb begin
        pready_s  = 1'b0;
        pslverr_s = 1'b0;
        if (psel_r && penable_r && (wait_cnt_r == WAIT_LIM)) begin
            pready_s  = 1'b1;
            pslverr_s = !addr_ok_s;
        end else begin
            pready_s  = 1'b0;
            pslverr_s = 1'b0;
        end
    end

    // Read data is driven only for an in-range read; anything else reads 0.
    always_comb begin
        prdata_s = '0;
        if (psel_r && !pwrite_r && addr_ok_s) begin
            prdata_s = mem_r[idx_s];
        end else begin
            prdata_s = '0;
        end
    end

    // Wait counter: counts ACCESS cycles, restarts whenever penable is low
    // and after the ready cycle so each transfer starts from zero.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt_r <= 3'd0;
        end else if (!penable_r || pready_s) begin
            wait_cnt_r <= 3'd0;
        end else begin
            wait_cnt_r <= wait_cnt_r + 3'd1;
        end
    end

    // Memory array: cleared by reset, written on the ready edge of an
    // in-range write.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            mem_r <= '{default: '0};
        end else if (pready_s && pwrite_r && addr_ok_s) begin
            mem_r[idx_s] <= pwdata_r;
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------------
    assign psel    = psel_r;
    assign penable = penable_r;
    assign pwrite  = pwrite_r;
    assign paddr   = paddr_r;
    assign pwdata  = pwdata_r;
    assign rdata   = rdata_r;
    assign done    = done_r;
    assign err     = err_r;
    assign prdata  = prdata_s;
    assign pready  = pready_s;
    assign pslverr = pslverr_s;

endmodule

// File: tb/tb_apb_master_slave_pair.sv
// ---------------------------------------------------------------------------
// Directed bench for apb_master_slave_pair. Two instances share clock and
// reset: dut0 with zero wait states and dut2 with two wait states.
// ---------------------------------------------------------------------------
module tb_apb_master_slave_pair;

    logic        pclk;
    logic        presetn;

    logic        start0, write0;
    logic [15:0] addr0, wdata0;
    logic [15:0] rdata0, paddr0, pwdata0, prdata0;
    logic        done0, err0, psel0, penable0, pwrite0, pready0, pslverr0;

    logic        start2, write2;
    logic [15:0] addr2, wdata2;
    logic [15:0] rdata2, paddr2, pwdata2, prdata2;
    logic        done2, err2, psel2, penable2, pwrite2, pready2, pslverr2;

    int vectors;
    int miscompares;

    apb_master_slave_pair #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_DEPTH(64), .WAIT_STATES(0)
    ) dut0 (
        .pclk(pclk), .presetn(presetn), .start(start0), .write(write0),
        .addr(addr0), .wdata(wdata0), .rdata(rdata0), .done(done0), .err(err0),
        .psel(psel0), .penable(penable0), .pwrite(pwrite0), .paddr(paddr0),
        .pwdata(pwdata0), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_master_slave_pair #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_DEPTH(64), .WAIT_STATES(2)
    ) dut2 (
        .pclk(pclk), .presetn(presetn), .start(start2), .write(write2),
        .addr(addr2), .wdata(wdata2), .rdata(rdata2), .done(done2), .err(err2),
        .psel(psel2), .penable(penable2), .pwrite(pwrite2), .paddr(paddr2),
        .pwdata(pwdata2), .prdata(prdata2), .pready(pready2), .pslverr(pslverr2)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive(input bit use2, input logic s, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        if (use2) begin
            start2 = s; write2 = w; addr2 = a; wdata2 = d;
        end else begin
            start0 = s; write0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    // One transfer with a one-cycle start pulse. lat counts cycles from the
    // start cycle to the done cycle (99 if done never came).
    task automatic xfer(input bit use2, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, output int lat, output int pen,
                        output int setup_cnt, output bit pw_seen,
                        output logic eflag, output logic [15:0] rd,
                        output logic done_after);
        bit   got;
        logic d_s, pe_s, ps_s, pw_s;
        drive(use2, 1'b1, wr, a, d);
        tick();
        drive(use2, 1'b0, wr, a, d);
        lat = 1; pen = 0; setup_cnt = 0; pw_seen = 1'b0; got = 1'b0;
        while (!got && lat < 20) begin
            d_s  = use2 ? done2    : done0;
            pe_s = use2 ? penable2 : penable0;
            ps_s = use2 ? psel2    : psel0;
            pw_s = use2 ? pwrite2  : pwrite0;
            if (d_s) begin
                got = 1'b1;
            end else begin
                if (ps_s && !pe_s) setup_cnt++;
                if (pe_s) pen++;
                if (ps_s && pw_s) pw_seen = 1'b1;
                tick();
                lat++;
            end
        end
        if (!got) lat = 99;
        eflag = use2 ? err2 : err0;
        rd    = use2 ? rdata2 : rdata0;
        tick();
        done_after = use2 ? done2 : done0;
    endtask

    initial begin
        int          lat, pen, setup_cnt;
        bit          pw_seen;
        logic        eflag, done_after;
        logic [15:0] rd;
        logic [5:0]  ps_v, pe_v, dn_v;

        vectors = 0;
        miscompares = 0;
        presetn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Reset state
        #2;
        check("rst_psel",    32'(psel0),    32'd0);
        check("rst_penable", 32'(penable0), 32'd0);
        check("rst_done",    32'(done0),    32'd0);
        check("rst_paddr",   32'(paddr0),   32'd0);
        check("rst_rdata",   32'(rdata0),   32'd0);
        #10;
        presetn = 1'b1;
        tick();

        // 1: write addr 5 = 1, zero wait states
        drive(1'b0, 1'b1, 1'b1, 16'd5, 16'h0001);
        tick();
        check("t1_setup_psel",    32'(psel0),    32'd1);
        check("t1_setup_penable", 32'(penable0), 32'd0);
        check("t1_setup_paddr",   32'(paddr0),   32'd5);
        check("t1_setup_pwrite",  32'(pwrite0),  32'd1);
        drive(1'b0, 1'b0, 1'b0, 16'd0, 16'h0000);
        tick();
        check("t1_access_penable", 32'(penable0), 32'd1);
        check("t1_access_pwdata",  32'(pwdata0),  32'h0001);
        check("t1_access_pready",  32'(pready0),  32'd1);
        check("t1_access_done",    32'(done0),    32'd0);
        tick();
        check("t1_done",     32'(done0),  32'd1);
        check("t1_err",      32'(err0),   32'd0);
        check("t1_idle_sel", 32'(psel0),  32'd0);
        check("t1_rdata",    32'(rdata0), 32'd0);
        tick();
        check("t1_done_once", 32'(done0), 32'd0);
        check("t1_hold_paddr", 32'(paddr0), 32'd5);

        // 2: read addr 5
        xfer(1'b0, 1'b0, 16'd5, 16'h0000, lat, pen, setup_cnt, pw_seen, eflag, rd, done_after);
        check("t2_lat",     32'(lat),        32'd3);
        check("t2_rdata",   32'(rd),         32'h0001);
        check("t2_err",     32'(eflag),      32'd0);
        check("t2_pwrite",  32'(pw_seen),    32'd0);
        check("t2_single",  32'(done_after), 32'd0);
        check("t2_setup",   32'(setup_cnt),  32'd1);

        // 3: two wait states on dut2
        xfer(1'b1, 1'b1, 16'd10, 16'hBEEF, lat, pen, setup_cnt, pw_seen, eflag, rd, done_after);
        check("t3w_lat",    32'(lat),   32'd5);
        check("t3w_pen",    32'(pen),   32'd3);
        check("t3w_err",    32'(eflag), 32'd0);
        xfer(1'b1, 1'b0, 16'd10, 16'h0000, lat, pen, setup_cnt, pw_seen, eflag, rd, done_after);
        check("t3r_lat",    32'(lat),   32'd5);
        check("t3r_pen",    32'(pen),   32'd3);
        check("t3r_rdata",  32'(rd),    32'h0000BEEF);
        check("t3r_single", 32'(done_after), 32'd0);

        // 4: out-of-range address 100 aliases index 36 but must not touch it
        xfer(1'b0, 1'b1, 16'd36, 16'h3636, lat, pen, setup_cnt, pw_seen, eflag, rd, done_after);
        xfer(1'b0, 1'b0, 16'd36, 16'h0000, lat, pen, setup_cnt, pw_seen, eflag, rd, done_after);
        check("t4_pre36",    32'(rd),    32'h3636);
        xfer(1'b0, 1'b1, 16'd100, 16'h1234, lat, pen, setup_cnt, pw_seen, eflag, rd, done_after);
        check("t4_werr",     32'(eflag), 32'd1);
        check("t4_wr_keeps_rdata", 32'(rd), 32'h3636);
        xfer(1'b0, 1'b0, 16'd100, 16'h0000, lat, pen, setup_cnt, pw_seen, eflag, rd, done_after);
        check("t4_rerr",     32'(eflag), 32'd1);
        check("t4_rdata",    32'(rd),    32'd0);
        xfer(1'b0, 1'b0, 16'd36, 16'h0000, lat, pen, setup_cnt, pw_seen, eflag, rd, done_after);
        check("t4_post36",   32'(rd),    32'h3636);
        check("t4_post_err", 32'(eflag), 32'd0);

        // 5: start held high -> SETUP, ACCESS, done, SETUP, ACCESS, done
        drive(1'b0, 1'b1, 1'b0, 16'd5, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            tick();
            ps_v[i] = psel0;
            pe_v[i] = penable0;
            dn_v[i] = done0;
        end
        drive(1'b0, 1'b0, 1'b0, 16'd5, 16'h0000);
        check("t5_psel_seq",    32'(ps_v), 32'b011011);
        check("t5_penable_seq", 32'(pe_v), 32'b010010);
        check("t5_done_seq",    32'(dn_v), 32'b100100);
        tick();
        tick();

        // 6: reset during ACCESS of a write to addr 7
        xfer(1'b0, 1'b1, 16'd7, 16'h0707, lat, pen, setup_cnt, pw_seen, eflag, rd, done_after);
        drive(1'b0, 1'b1, 1'b1, 16'd7, 16'h7777);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'd0, 16'h0000);
        tick();
        check("t6_in_access", 32'(penable0), 32'd1);
        presetn = 1'b0;
        #1;
        check("t6_psel",    32'(psel0),    32'd0);
        check("t6_penable", 32'(penable0), 32'd0);
        check("t6_pwrite",  32'(pwrite0),  32'd0);
        check("t6_paddr",   32'(paddr0),   32'd0);
        check("t6_pwdata",  32'(pwdata0),  32'd0);
        check("t6_rdata",   32'(rdata0),   32'd0);
        check("t6_err",     32'(err0),     32'd0);
        tick();
        check("t6_no_done_a", 32'(done0), 32'd0);
        presetn = 1'b1;
        tick();
        check("t6_no_done_b", 32'(done0), 32'd0);
        xfer(1'b0, 1'b0, 16'd7, 16'h0000, lat, pen, setup_cnt, pw_seen, eflag, rd, done_after);
        check("t6_rd7", 32'(rd),  32'd0);
        check("t6_lat", 32'(lat), 32'd3);
        xfer(1'b0, 1'b0, 16'd5, 16'h0000, lat, pen, setup_cnt, pw_seen, eflag, rd, done_after);
        check("t6_rd5_cleared", 32'(rd), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_master_slave_pair.md
Name: apb_master_slave_pair

Overview:
- Self-contained APB subsystem with two parts:
  - An APB master. It converts a single-cycle user `start` request into a standard APB3 SETUP/ACCESS transfer.
  - An APB slave. It is a register-file memory with a configurable number of wait states.
- Used as a reusable bus-access block and as the reference APB endpoint for peripheral bring-up.
- APB bus signals are exported as outputs for observability only.

Parameters:
- ADDR_WIDTH, 16: width of `addr` and `paddr`.
- DATA_WIDTH, 16: width of `wdata`, `rdata`, `pwdata` and `prdata`.
- MEM_DEPTH, 64: number of slave words. Valid addresses are 0 to MEM_DEPTH-1.
- WAIT_STATES, 0: ACCESS cycles with pready low before pready rises. Legal range is 0 to 7.

Ports:
- pclk      in   1           clock, all logic on the rising edge
- presetn   in   1           reset, asynchronous, active-low
- start     in   1           request pulse, sampled only while the master is idle
- write     in   1           1 = write, 0 = read; captured with `start`
- addr      in   ADDR_WIDTH  transfer address, captured with `start`
- wdata     in   DATA_WIDTH  write data, captured with `start`
- rdata     out  DATA_WIDTH  read data from the last completed read
- done      out  1           one-cycle completion pulse
- err       out  1           slave error of the last transfer; valid while `done` is high
- psel, penable, pwrite     out  1           observed APB control signals
- paddr     out  ADDR_WIDTH  observed APB address
- pwdata    out  DATA_WIDTH  observed APB write data
- prdata    out  DATA_WIDTH  observed APB read data
- pready, pslverr           out  1           observed APB slave response

Behaviour:
- Reset (presetn low, asynchronous):
  - Master returns to IDLE.
  - psel, penable, pwrite, done and err are 0; paddr, pwdata and rdata are 0.
  - Slave memory clears to 0 and its wait counter clears.
  - Reset during a transfer aborts it; no done pulse follows.
- Master FSM:
  - IDLE:
    - psel=0, penable=0.
    - When start=1 at a rising edge: latch addr→paddr, write→pwrite, wdata→pwdata; go to SETUP.
  - SETUP:
    - psel=1, penable=0, for exactly one cycle.
    - Then go to ACCESS.
  - ACCESS:
    - psel=1, penable=1. paddr, pwrite and pwdata stay stable.
    - When pready=1 at a rising edge:
      - the transfer completes;
      - on a read, rdata ← prdata;
      - err ← pslverr;
      - done=1 for the following cycle;
      - go to IDLE.
    - When pready=0, stay in ACCESS.
- Timing:
  - With start sampled at edge E0: SETUP follows E0, ACCESS follows E1, completion is at edge E(2+WAIT_STATES), and done is high during the next cycle.
  - Zero-wait latency is 3 cycles from start to done.
- Start handling:
  - start is ignored outside IDLE; there is no queueing.
  - start in the same cycle that done is high is accepted, because the master is already IDLE.
- Output holding:
  - rdata holds its value until the next completed read; writes do not change it.
  - paddr, pwrite and pwdata hold their last values while IDLE.
- Slave wait states:
  - The wait counter counts ACCESS cycles.
  - pready = psel & penable & (count == WAIT_STATES).
  - The counter clears when penable is low.
- Slave write:
  - When pready & pwrite and the address is valid, mem[paddr] ← pwdata at that edge.
- Slave read:
  - prdata = mem[paddr] combinationally while psel & !pwrite and the address is valid; otherwise prdata = 0.
- Slave error:
  - pslverr = pready & (paddr ≥ MEM_DEPTH).
  - An out-of-range write does not modify memory.
  - An out-of-range read returns 0; the master still captures it into rdata.
- Width rules:
  - Memory is indexed by the paddr bits needed for MEM_DEPTH, after the range check on the full paddr.

Test Plan:
1. Reset, then write addr=5, wdata=1 with a one-cycle start pulse.
   - Required: the SETUP then ACCESS sequence; done pulses once, 3 cycles after start; err=0.
2. Read addr=5.
   - Required: rdata=16'h0001, done pulses once, err=0, pwrite=0 throughout.
3. WAIT_STATES=2: write addr=10, wdata=16'hBEEF, then read it back.
   - Required: penable is high for 3 cycles per transfer; done comes 5 cycles after start; rdata=16'hBEEF.
4. Write addr=100 (≥ MEM_DEPTH) with 16'h1234, then read addr=100.
   - Required: err=1 on both done pulses; rdata=0; a read of addr 36 (the aliased index) still returns its prior value.
5. Hold start=1 continuously through a transfer.
   - Required: a new transfer begins only from IDLE; back-to-back transfers are separated by the done cycle; no overlapping SETUP.
6. Assert presetn=0 during ACCESS of a write to addr=7.
   - Required: all outputs reach their reset values immediately; no done pulse; a read of addr=7 after reset returns 0.
